// File: rtl/rv32_pipe_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pipe_pkg
//
// Shared definitions for the RV32 5-stage pipeline control slice.
//
// Contents:
//   NUM_WIDTH_DEF - default register-number width (5 bits -> x0..x31)
//   REG_X0        - register number of the hard-wired zero register
//   pipe_state_e  - scheduler state encoding (ST_RUN / ST_SQUASH)
//   pipe_ctrl_t   - bundle of the five pipeline control strobes
// ----------------------------------------------------------------------------
package rv32_pipe_pkg;

    localparam int NUM_WIDTH_DEF = 5;
    localparam int REG_X0        = 0;

    // ST_RUN    : normal operation.
    // ST_SQUASH : a fetch issued on the abandoned path is still in flight and
    //             its returning word must be thrown away.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } pipe_state_e;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hazard;
        logic ifid_flush;
        logic idex_flush;
        logic back_hold;
    } pipe_ctrl_t;

endpackage : rv32_pipe_pkg

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
//
// Combinational load-use comparator. Flags the case where the instruction in
// ID reads a register that the load currently in EX is about to write, so the
// ID instruction must wait one cycle for the load data.
//
// Ports:
//   id_rd_num1   in  [NUM_WIDTH] ID source register 1
//   id_rd_num2   in  [NUM_WIDTH] ID source register 2
//   id_rs1_used  in  1           ID instruction actually reads rs1
//   id_rs2_used  in  1           ID instruction actually reads rs2
//   ex_mem_read  in  1           EX instruction is a load
//   ex_wr_num    in  [NUM_WIDTH] EX destination register
//   load_use     out 1           load-use hazard present this cycle
// ----------------------------------------------------------------------------
module hazard_detect
    import rv32_pipe_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
    input  logic [NUM_WIDTH-1:0] id_rd_num1,
    input  logic [NUM_WIDTH-1:0] id_rd_num2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 ex_mem_read,
    input  logic [NUM_WIDTH-1:0] ex_wr_num,
    output logic                 load_use
);

    logic wr_live;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        // A load targeting x0 writes nothing, so it can never create a hazard.
        wr_live  = (ex_wr_num != NUM_WIDTH'(REG_X0));
        rs1_hit  = id_rs1_used && (id_rd_num1 == ex_wr_num);
        rs2_hit  = id_rs2_used && (id_rd_num2 == ex_wr_num);
        load_use = ex_mem_read && wr_live && (rs1_hit || rs2_hit);
    end

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush scheduler for the RV32 5-stage pipeline. Arbitrates
// data-memory waits, taken-branch redirects, load-use hazards and fetch waits
// under a single fixed priority and drives the PC / IF/ID / ID/EX / back-end
// control strobes. Tracks a fetch left in flight by a redirect (SQUASH) so
// that the stale word is discarded when it finally arrives.
//
// Optional feature (macro PIPE_PERF_CNT_EN): saturating stall and redirect
// flush counters, exposed as stall_cnt / flush_cnt.
//
// Ports:
//   clk              in  1           clock, rising edge
//   rst              in  1           synchronous active-high reset
//   id_rd_num1/2     in  [NUM_WIDTH] ID source registers
//   id_rs1/2_used    in  1           ID instruction reads rs1 / rs2
//   ex_mem_read      in  1           EX instruction is a load
//   ex_wr_num        in  [NUM_WIDTH] EX destination register
//   ex_branch_taken  in  1           EX redirects the PC this cycle
//   imem_ready       in  1           fetch data valid (level)
//   dmem_req         in  1           MEM access issued (one-cycle pulse)
//   dmem_ready       in  1           MEM access complete
//   pc_hold          out 1           PC keeps its value
//   ifid_hazard      out 1           IF/ID holds its contents
//   ifid_flush       out 1           IF/ID clears on the next edge
//   idex_flush       out 1           ID/EX loads a bubble
//   back_hold        out 1           ID/EX, EX/MEM, MEM/WB hold
//   state_o          out 1           0=RUN, 1=SQUASH
//   stall_cnt        out [CNT_WIDTH] cycles with pc_hold=1 (feature only)
//   flush_cnt        out [CNT_WIDTH] redirect/squash flush cycles (feature only)
//
// Handshake: imem_ready is a level that stays stable while pc_hold=1;
// dmem_req is a single-cycle pulse per access and the access is outstanding
// until the cycle in which dmem_ready=1.
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WIDTH-1:0] id_rd_num1,
    input  logic [NUM_WIDTH-1:0] id_rd_num2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 ex_mem_read,
    input  logic [NUM_WIDTH-1:0] ex_wr_num,
    input  logic                 ex_branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_hold,
    output logic                 ifid_hazard,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 back_hold,
    output logic                 state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    pipe_state_e state_q, state_d;
    logic        dpend_q, dpend_d;
    logic        freeze;
    logic        load_use;
    pipe_ctrl_t  ctrl;
    logic        redirect_flush;

    hazard_detect #(
        .NUM_WIDTH (NUM_WIDTH)
    ) u_hazard_detect (
        .id_rd_num1  (id_rd_num1),
        .id_rd_num2  (id_rd_num2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_mem_read (ex_mem_read),
        .ex_wr_num   (ex_wr_num),
        .load_use    (load_use)
    );

    // ------------------------------------------------------------------
    // Data-memory wait tracking. dpend remembers an access that was issued
    // but not completed in its request cycle; the back end freezes until
    // the completion cycle, which itself is not frozen.
    // ------------------------------------------------------------------
    always_comb begin
        freeze  = (dmem_req | dpend_q) & ~dmem_ready;
        dpend_d = dpend_q;
        if (dmem_ready) begin
            dpend_d = 1'b0;
        end else if (dmem_req) begin
            dpend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler: control strobes and next state.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl           = '0;
        state_d        = state_q;
        redirect_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    // Whole pipe waits on the data memory. A branch in EX is
                    // held there and gets serviced once the access completes.
                    ctrl.pc_hold     = 1'b1;
                    ctrl.ifid_hazard = 1'b1;
                    ctrl.back_hold   = 1'b1;
                end else if (ex_branch_taken) begin
                    // PC loads the target; the two younger instructions die.
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    redirect_flush  = 1'b1;
                    // A fetch still outstanding belongs to the wrong path.
                    if (!imem_ready) begin
                        state_d = ST_SQUASH;
                    end
                end else if (load_use) begin
                    // One-cycle bubble: the load leaves EX next cycle.
                    ctrl.pc_hold     = 1'b1;
                    ctrl.ifid_hazard = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                end else if (!imem_ready) begin
                    // Fetch bubble: nothing valid to pass into ID.
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                end
            end

            ST_SQUASH: begin
                // The stale fetch is still outstanding: keep the PC on the
                // target and keep discarding whatever IF presents.
                ctrl.pc_hold    = 1'b1;
                ctrl.ifid_flush = 1'b1;
                redirect_flush  = 1'b1;
                if (freeze) begin
                    ctrl.back_hold = 1'b1;
                end
                if (!freeze && ex_branch_taken) begin
                    // A newer redirect: load the new target, kill ID/EX and
                    // keep squashing since a fetch is still in flight.
                    ctrl.pc_hold    = 1'b0;
                    ctrl.idex_flush = 1'b1;
                end else if (imem_ready) begin
                    // Stale word arrives this cycle and is flushed.
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            ctrl           = '0;
            redirect_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            dpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dpend_q <= dpend_d;
        end
    end

    assign pc_hold     = ctrl.pc_hold;
    assign ifid_hazard = ctrl.ifid_hazard;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign back_hold   = ctrl.back_hold;
    assign state_o     = rst ? 1'b0 : (state_q == ST_SQUASH);

`ifdef PIPE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl.pc_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        // Fetch bubbles also raise ifid_flush but are not counted here.
        if (redirect_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the
// scheduling rules. Honors PIPE_PERF_CNT_EN for the counter outputs.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int NW = 5;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NW-1:0] id_rd_num1, id_rd_num2, ex_wr_num;
    logic          id_rs1_used, id_rs2_used, ex_mem_read;
    logic          ex_branch_taken, imem_ready, dmem_req, dmem_ready;
    logic          pc_hold, ifid_hazard, ifid_flush, idex_flush, back_hold, state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    pipeline_ctrl #(
        .NUM_WIDTH (NW)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_WIDTH (CW)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rd_num1      (id_rd_num1),
        .id_rd_num2      (id_rd_num2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_mem_read     (ex_mem_read),
        .ex_wr_num       (ex_wr_num),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_hold         (pc_hold),
        .ifid_hazard     (ifid_hazard),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .back_hold       (back_hold),
        .state_o         (state_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    // ---------------- stimulus record ----------------
    typedef struct packed {
        logic          rst;
        logic [NW-1:0] rs1;
        logic [NW-1:0] rs2;
        logic          rs1_used;
        logic          rs2_used;
        logic          mem_read;
        logic [NW-1:0] wr;
        logic          br;
        logic          imem;
        logic          dreq;
        logic          dready;
    } stim_t;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model state ----------------
    // stale_fetch : a wrong-path fetch is still coming back
    // mem_busy    : a data access was issued and has not completed
    bit            stale_fetch = 1'b0;
    bit            mem_busy    = 1'b0;
    logic [CW-1:0] exp_stall   = '0;
    logic [CW-1:0] exp_flush   = '0;

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.imem = 1'b1;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check mid-low-phase,
    // then advance the model to what the coming rising edge will produce.
    task automatic step(input stim_t s, input string tag);
        logic e_ph, e_hz, e_ff, e_xf, e_bh, e_st;
        logic mem_blocked, lu, fetch_bubble, next_stale;
        @(negedge clk);
        rst             = s.rst;
        id_rd_num1      = s.rs1;
        id_rd_num2      = s.rs2;
        id_rs1_used     = s.rs1_used;
        id_rs2_used     = s.rs2_used;
        ex_mem_read     = s.mem_read;
        ex_wr_num       = s.wr;
        ex_branch_taken = s.br;
        imem_ready      = s.imem;
        dmem_req        = s.dreq;
        dmem_ready      = s.dready;
        #2;

        {e_ph, e_hz, e_ff, e_xf, e_bh} = '0;
        fetch_bubble = 1'b0;
        next_stale   = stale_fetch;
        mem_blocked  = (s.dreq || mem_busy) && !s.dready;
        lu = s.mem_read && (s.wr != 0) &&
             ((s.rs1_used && (s.rs1 == s.wr)) || (s.rs2_used && (s.rs2 == s.wr)));

        if (!s.rst) begin
            if (stale_fetch) begin
                e_ph = 1'b1;
                e_ff = 1'b1;
                e_bh = mem_blocked;
                if (!mem_blocked && s.br) begin
                    e_ph       = 1'b0;
                    e_xf       = 1'b1;
                    next_stale = 1'b1;
                end else begin
                    next_stale = !s.imem;
                end
            end else if (mem_blocked) begin
                e_ph = 1'b1;
                e_hz = 1'b1;
                e_bh = 1'b1;
            end else if (s.br) begin
                e_ff       = 1'b1;
                e_xf       = 1'b1;
                next_stale = !s.imem;
            end else if (lu) begin
                e_ph = 1'b1;
                e_hz = 1'b1;
                e_xf = 1'b1;
            end else if (!s.imem) begin
                e_ph         = 1'b1;
                e_ff         = 1'b1;
                fetch_bubble = 1'b1;
            end
        end
        e_st = s.rst ? 1'b0 : stale_fetch;

        check({tag, ".pc_hold"},     32'(pc_hold),     32'(e_ph));
        check({tag, ".ifid_hazard"}, 32'(ifid_hazard), 32'(e_hz));
        check({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_ff));
        check({tag, ".idex_flush"},  32'(idex_flush),  32'(e_xf));
        check({tag, ".back_hold"},   32'(back_hold),   32'(e_bh));
        check({tag, ".state_o"},     32'(state_o),     32'(e_st));
        check({tag, ".hz_and_flush"}, 32'(ifid_hazard & ifid_flush), 32'(0));
`ifdef PIPE_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
        check({tag, ".flush_cnt"}, flush_cnt, exp_flush);
`endif

        if (s.rst) begin
            stale_fetch = 1'b0;
            mem_busy    = 1'b0;
            exp_stall   = '0;
            exp_flush   = '0;
        end else begin
            stale_fetch = next_stale;
            if (s.dready)    mem_busy = 1'b0;
            else if (s.dreq) mem_busy = 1'b1;
            if (e_ph && exp_stall != '1) exp_stall = exp_stall + 1;
            if (e_ff && !fetch_bubble && exp_flush != '1) exp_flush = exp_flush + 1;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        stim_t s;
        rst = 1'b1;
        {id_rd_num1, id_rd_num2, ex_wr_num} = '0;
        {id_rs1_used, id_rs2_used, ex_mem_read} = '0;
        {ex_branch_taken, dmem_req, dmem_ready} = '0;
        imem_ready = 1'b1;

        // Reset
        s = idle(); s.rst = 1'b1;
        step(s, "reset0");
        step(s, "reset1");
        step(idle(), "idle0");

        // Load-use on rs1, then release
        s = idle(); s.mem_read = 1'b1; s.wr = 5'd5; s.rs1 = 5'd5; s.rs1_used = 1'b1;
        step(s, "lu_rs1");
        step(idle(), "lu_rs1_after");
        // Same pattern with x0 destination: no stall
        s.wr = 5'd0; s.rs1 = 5'd0;
        step(s, "lu_x0");
        // Load-use on rs2; rs2 match but unused must not stall
        s = idle(); s.mem_read = 1'b1; s.wr = 5'd9; s.rs2 = 5'd9; s.rs2_used = 1'b1;
        step(s, "lu_rs2");
        s.rs2_used = 1'b0;
        step(s, "lu_rs2_unused");
        // Load-use with a fetch wait: load-use wins
        s = idle(); s.mem_read = 1'b1; s.wr = 5'd3; s.rs1 = 5'd3; s.rs1_used = 1'b1; s.imem = 1'b0;
        step(s, "lu_and_fetch");
        s = idle(); s.imem = 1'b0;
        step(s, "fetch_bubble");
        step(idle(), "fetch_done");

        // Branch with fetch ready
        s = idle(); s.br = 1'b1;
        step(s, "br_ready");
        step(idle(), "br_ready_after");

        // Branch with fetch outstanding -> SQUASH, 3 wait cycles, release
        s = idle(); s.br = 1'b1; s.imem = 1'b0;
        step(s, "br_miss");
        s = idle(); s.imem = 1'b0;
        step(s, "sq_wait0");
        step(s, "sq_wait1");
        step(s, "sq_wait2");
        step(idle(), "sq_release");
        step(idle(), "sq_back_run");

        // Data wait of three cycles
        s = idle(); s.dreq = 1'b1;
        step(s, "dwait0");
        step(idle(), "dwait1");
        step(idle(), "dwait2");
        s = idle(); s.dready = 1'b1;
        step(s, "dwait_done");
        step(idle(), "dwait_after");

        // Data wait together with a branch: freeze first, then the branch
        s = idle(); s.dreq = 1'b1; s.br = 1'b1;
        step(s, "dbr0");
        s.dreq = 1'b0;
        step(s, "dbr1");
        s.dready = 1'b1;
        step(s, "dbr_done");
        step(idle(), "dbr_after");

        // Reset while squashing with a data wait pending
        s = idle(); s.br = 1'b1; s.imem = 1'b0;
        step(s, "rsq_br");
        s = idle(); s.imem = 1'b0; s.dreq = 1'b1;
        step(s, "rsq_dreq");
        s = idle(); s.imem = 1'b0; s.rst = 1'b1;
        step(s, "rsq_rst");
        step(idle(), "rsq_after");
        step(idle(), "rsq_after2");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            s          = '0;
            s.rst      = ($urandom_range(0, 59) == 0);
            s.rs1      = NW'($urandom_range(0, 3));
            s.rs2      = NW'($urandom_range(0, 3));
            s.rs1_used = 1'($urandom_range(0, 1));
            s.rs2_used = 1'($urandom_range(0, 1));
            s.mem_read = ($urandom_range(0, 2) == 0);
            s.wr       = NW'($urandom_range(0, 3));
            s.br       = ($urandom_range(0, 5) == 0);
            s.imem     = ($urandom_range(0, 3) != 0);
            s.dreq     = ($urandom_range(0, 7) == 0);
            s.dready   = ($urandom_range(0, 2) == 0);
            step(s, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_ctrl

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the RV32 5-stage pipeline.
- Drives the PC hold, the IF/ID register hold (`hazard`) and clear (`flush`), the ID/EX bubble, and the back-end freeze.
- Resolves load-use hazards, taken-branch redirects, multi-cycle instruction-fetch waits and multi-cycle data-memory waits under one fixed priority.
- Squashes a fetch still in flight when a branch redirects the PC.

Parameters:
- NUM_WIDTH, 5, register-number width.
- CNT_WIDTH, 32, width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- id_rd_num1  input  NUM_WIDTH  ID-stage source register 1.
- id_rd_num2  input  NUM_WIDTH  ID-stage source register 2.
- id_rs1_used  input  1  ID instruction reads rs1.
- id_rs2_used  input  1  ID instruction reads rs2.
- ex_mem_read  input  1  EX-stage instruction is a load.
- ex_wr_num  input  NUM_WIDTH  EX-stage destination register.
- ex_branch_taken  input  1  EX-stage branch/jump redirects the PC this cycle.
- imem_ready  input  1  fetch data valid; level signal, held stable while pc_hold=1.
- dmem_req  input  1  MEM-stage access issued; single-cycle pulse.
- dmem_ready  input  1  data-memory access complete.
- pc_hold  output  1  PC keeps its value.
- ifid_hazard  output  1  IF/ID holds its contents.
- ifid_flush  output  1  IF/ID clears on the next edge.
- idex_flush  output  1  ID/EX loads a bubble.
- back_hold  output  1  ID/EX, EX/MEM and MEM/WB hold.
- state_o  output  1  current FSM state (0=RUN, 1=SQUASH).

Behaviour:
- All outputs are combinational from state, the dpend flag and the inputs.
- Reset (rst=1 at an edge): state=RUN, dpend=0, counters=0. This applies mid-operation too: a pending squash or data wait is dropped.
- With rst held, every output is forced to 0, state_o=0.
- dpend flag:
  - Set when dmem_req=1 and dmem_ready=0.
  - Cleared when dmem_ready=1.
  - freeze = (dmem_req | dpend) & ~dmem_ready.
- RUN priority, highest first:
  1. freeze: pc_hold=1, ifid_hazard=1, back_hold=1, ifid_flush=0, idex_flush=0.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_hold=0 (PC loads the target). If imem_ready=0, next state is SQUASH.
  3. Load-use, when ex_mem_read=1, ex_wr_num!=0, and ((id_rs1_used && id_rd_num1==ex_wr_num) || (id_rs2_used && id_rd_num2==ex_wr_num)): pc_hold=1, ifid_hazard=1, idex_flush=1. Lasts exactly 1 cycle, because the load leaves EX.
  4. imem_ready=0: pc_hold=1, ifid_flush=1 (fetch bubble).
  5. Otherwise all outputs are 0.
- SQUASH state:
  - The old-path fetch is outstanding, so pc_hold=1 and ifid_flush=1 every cycle.
  - freeze additionally asserts back_hold=1.
  - ex_branch_taken in SQUASH (only possible when not frozen): idex_flush=1, pc_hold=0 (new target loaded); stay in SQUASH.
  - On imem_ready=1 the stale word is discarded (ifid_flush=1), then next state is RUN.
- Simultaneous events:
  - Branch and freeze in the same cycle: freeze wins. The branch stays asserted because EX is held, and is serviced after dmem_ready.
  - Load-use and imem_ready=0 together: load-use outputs apply.
- Output invariant: ifid_hazard and ifid_flush are never both 1.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - Adds outputs stall_cnt and flush_cnt, each CNT_WIDTH wide, reset to 0, saturating at all-ones.
  - stall_cnt increments each cycle pc_hold=1.
  - flush_cnt increments each cycle ifid_flush=1 caused by a branch or squash (not fetch bubbles).
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rv32_pipe_pkg holds:
  - state encoding constants ST_RUN=1'b0, ST_SQUASH=1'b1;
  - NUM_WIDTH default;
  - x0 register constant.
- One sub-module, hazard_detect: the combinational load-use comparator (inputs id_*, ex_*; output load_use).

Test Plan:
- Load-use: ex_mem_read=1, ex_wr_num=5, id_rd_num1=5, id_rs1_used=1 -> one cycle of pc_hold=1, ifid_hazard=1, idex_flush=1; all outputs 0 the next cycle. Repeat with ex_wr_num=0 -> no stall.
- Branch with imem_ready=1: ex_branch_taken pulse -> ifid_flush=1, idex_flush=1, pc_hold=0; state stays RUN.
- Branch with imem_ready=0 -> state_o=1. imem_ready held 0 for 3 cycles -> pc_hold=1, ifid_flush=1 each cycle. imem_ready=1 -> flush once more, then RUN.
- dmem_req pulse, dmem_ready rises 3 cycles later -> back_hold, pc_hold and ifid_hazard high for exactly 3 cycles; low on the dmem_ready cycle.
- dmem stall together with ex_branch_taken=1 -> freeze outputs only. On dmem_ready -> branch flush outputs in that cycle.
- rst asserted while in SQUASH with dpend=1 -> next cycle state_o=0, all outputs 0, counters 0 (PIPE_PERF_CNT_EN build).
